// File: rtl/reg_transfer_unit.sv
// Source register bank with one-hot transfer into an accumulator plus a scan FSM.
// Ports: clk/rst_n, wr_en/wr_addr/wr_data, sel/op/start/clr_err, dout/carry/valid/busy/done/err.
module reg_transfer_unit #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NREGS-1:0] sel,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;

  state_t           state, state_n;
  logic [WIDTH-1:0] src [NREGS];
  logic [AW-1:0]    idx, idx_n;
  logic [1:0]       opc, opc_n;
  logic [WIDTH-1:0] dout_n;
  logic             carry_n, valid_n, err_n;
  logic [AW-1:0]    sidx;
  logic             multi;
  logic [WIDTH:0]   res;

  // {carry_out, result}; carry_out is zero for non-ADD ops.
  function automatic logic [WIDTH:0] alu(
    input logic [1:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    unique case (o)
      OP_MOVE: r = {1'b0, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  always_comb begin
    sidx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel[i]) sidx = AW'(i);
    end
  end

  assign multi = |(sel & (sel - 1'b1));
  assign busy  = (state != IDLE);
  assign done  = (state == FIN);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    opc_n   = opc;
    dout_n  = dout;
    carry_n = carry;
    valid_n = 1'b0;
    err_n   = clr_err ? 1'b0 : err;
    res     = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          idx_n   = '0;
          opc_n   = op;
          dout_n  = (op == OP_AND) ? '1 : '0;
          carry_n = 1'b0;
        end else if (multi) begin
          err_n = 1'b1;
        end else if (|sel) begin
          res     = alu(op, dout, src[sidx]);
          dout_n  = res[WIDTH-1:0];
          carry_n = res[WIDTH];
          valid_n = 1'b1;
        end
      end
      SCAN: begin
        res    = alu(opc, dout, src[idx]);
        dout_n = res[WIDTH-1:0];
        if (opc == OP_ADD) carry_n = carry | res[WIDTH];
        idx_n = idx + AW'(1);
        if (idx == AW'(NREGS - 1)) state_n = FIN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      opc   <= '0;
      dout  <= '0;
      carry <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) src[i] <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      opc   <= opc_n;
      dout  <= dout_n;
      carry <= carry_n;
      valid <= valid_n;
      err   <= err_n;
      if (wr_en && (int'(wr_addr) < NREGS)) src[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Directed bench for reg_transfer_unit with hand-computed expectations.
// Drives inputs 1ns after each rising edge and checks there too.
module tb_reg_transfer_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] sel;
  logic [1:0] op;
  logic       start;
  logic       clr_err;
  logic [7:0] dout;
  logic       carry, valid, busy, done, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_transfer_unit #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .op(op), .start(start), .clr_err(clr_err),
    .dout(dout), .carry(carry), .valid(valid),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic c,
                         input logic v, input logic b, input logic dn, input logic e);
    chk({tag, ".dout"},  32'(dout),  32'(d));
    chk({tag, ".carry"}, 32'(carry), 32'(c));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(dn));
    chk({tag, ".err"},   32'(err),   32'(e));
  endtask

  initial begin
    logic [7:0] pre [4];
    pre[0] = 8'h0A; pre[1] = 8'h0F; pre[2] = 8'hF0; pre[3] = 8'hFF;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sel = '0; op = 2'b00; start = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk_all("reset", 8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = pre[i];
      tick();
    end
    wr_en = 1'b0;
    chk_all("preload", 8'h00, 0, 0, 0, 0, 0);

    op = 2'b00; sel = 4'b0001; tick();
    chk_all("move0", 8'h0A, 0, 1, 0, 0, 0);
    sel = 4'b0000; tick();
    chk_all("hold", 8'h0A, 0, 0, 0, 0, 0);

    op = 2'b01; sel = 4'b0010; tick();
    chk_all("add1", 8'h19, 0, 1, 0, 0, 0);
    sel = 4'b1000; tick();
    chk_all("add3", 8'h18, 1, 1, 0, 0, 0);
    sel = 4'b0000; tick();

    op = 2'b00; sel = 4'b0011; tick();
    chk_all("multihot", 8'h18, 1, 0, 0, 0, 1);
    sel = 4'b0000; tick();
    chk("err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1; tick();
    chk("err_clr", 32'(err), 32'd0);
    sel = 4'b0011; tick();
    chk("err_clr_and_set", 32'(err), 32'd1);
    sel = 4'b0000; tick();
    chk("err_clr2", 32'(err), 32'd0);
    clr_err = 1'b0;

    op = 2'b11; start = 1'b1; tick();
    start = 1'b0;
    chk_all("xor_k", 8'h00, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("xor_busy", 32'({busy, done}), 32'b10);
    end
    tick();
    chk_all("xor_done", 8'h0A, 0, 0, 1, 1, 0);
    tick();
    chk_all("xor_idle", 8'h0A, 0, 0, 0, 0, 0);

    op = 2'b01; start = 1'b1; tick();
    chk_all("add_k", 8'h00, 0, 0, 1, 0, 0);
    op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      sel = (i % 2 == 0) ? 4'b0011 : 4'b0001;
      start = 1'b1;
      tick();
      chk("add_busy", 32'({busy, done}), 32'b10);
    end
    tick();
    chk_all("add_done", 8'h08, 1, 0, 1, 1, 0);
    sel = 4'b0001; start = 1'b1; tick();
    chk_all("done_ignores", 8'h08, 1, 0, 0, 0, 0);
    sel = 4'b0000; start = 1'b0;

    op = 2'b00; sel = 4'b0100;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h00; tick();
    wr_en = 1'b0;
    chk_all("rd_old", 8'hF0, 0, 1, 0, 0, 0);
    tick();
    chk_all("rd_new", 8'h00, 0, 1, 0, 0, 0);
    sel = 4'b0000;

    op = 2'b10; start = 1'b1; tick();
    start = 1'b0;
    chk_all("and_k", 8'hFF, 0, 0, 1, 0, 0);
    tick(); tick(); tick(); tick();
    chk_all("and_done", 8'h00, 0, 0, 1, 1, 0);
    tick();

    op = 2'b11; start = 1'b1; tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0; tick();
    chk_all("rst_mid", 8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1; tick();
    chk_all("rst_after", 8'h00, 0, 0, 0, 0, 0);
    tick();
    chk("rst_nodone", 32'(done), 32'd0);
    op = 2'b00; sel = 4'b1000; tick();
    chk_all("src_cleared", 8'h00, 0, 1, 0, 0, 0);
    sel = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_transfer_unit.md
Name: reg_transfer_unit

Overview:
- Parametrised successor to the fixed four-register, one-hot transfer datapath.
- Holds NREGS source registers of WIDTH bits and one destination accumulator (dout).
- Moves or combines a source into dout under one-hot control (manual mode), or under an internal scan FSM that folds all sources into dout in sequence.
- Sits between the register-load logic and downstream consumers of the accumulated result.

Parameters:
- WIDTH, 8: data width of every register.
- NREGS, 4: number of source registers and width of sel.
- AW, $clog2(NREGS): width of wr_addr.

Ports:
- clk  in  1  single rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write wr_data into src[wr_addr].
- wr_addr  in  AW  source register index.
- wr_data  in  WIDTH  source write data.
- sel  in  NREGS  one-hot manual transfer control; bit i selects src[i].
- op  in  2  00 MOVE, 01 ADD, 10 AND, 11 XOR.
- start  in  1  launch scan of all sources.
- clr_err  in  1  clear sticky err.
- dout  out  WIDTH  destination accumulator.
- carry  out  1  ADD carry flag.
- valid  out  1  one-cycle pulse: dout updated by a manual transfer.
- busy  out  1  scan in progress (state != IDLE).
- done  out  1  one-cycle pulse: scan finished.
- err  out  1  sticky multi-hot sel error.

Behaviour:
- Reset (rst_n=0 at an edge) forces IDLE and clears all src[], dout, carry, valid, busy, done and err. This applies mid-scan too: no done pulse, scan abandoned.
- Function f(op,a,b):
  - MOVE gives b.
  - ADD gives (a+b) mod 2^WIDTH, with carry-out.
  - AND gives a&b.
  - XOR gives a^b.
- Source writes: wr_en at an edge writes src[wr_addr]; wr_addr >= NREGS is ignored. Writes are allowed in every state. A read of the same register in the same cycle sees the old value.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1 (start takes priority over sel):
  - go to SCAN, idx <= 0.
  - dout <= all-ones if op=AND, else 0.
  - carry <= 0.
  - op is captured for the whole scan.
- IDLE, start=0, sel one-hot at bit i:
  - dout <= f(op, dout, src[i]) at that edge.
  - valid=1 for the following cycle.
  - carry <= ADD carry-out; carry <= 0 for other ops.
- IDLE, sel=0: hold.
- IDLE, sel multi-hot: no dout/carry change, valid=0, err <= 1 (sticky).
- SCAN:
  - each edge does dout <= f(op_cap, dout, src[idx]).
  - for ADD, carry <= carry | carry-out; otherwise carry is unchanged.
  - idx increments; after idx=NREGS-1, go to DONE.
  - sel, start and op are ignored.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE. sel/start are ignored in this cycle.
- Timing: start sampled at edge k.
  - busy=1 from after edge k until edge k+NREGS+1.
  - dout is final after edge k+NREGS.
  - done is high between edges k+NREGS and k+NREGS+1.
- Error flag: clr_err clears err at the next edge. If clr_err and a multi-hot sel occur on the same edge, err ends at 1.
- valid and done are never high in the same cycle.

Test Plan:
- Preload src = {0x0A, 0x0F, 0xF0, 0xFF}; op=MOVE, sel=0001 -> dout=0x0A, valid high 1 cycle, carry=0.
- From dout=0x0A, op=ADD, sel=0010 -> dout=0x19, carry=0. Then sel=1000 -> dout=0x18, carry=1.
- sel=0011 with any op -> dout unchanged, valid=0, err=1 and stays 1. Pulse clr_err -> err=0.
- start with op=XOR -> busy high 5 cycles, done pulses on cycle 5, dout=0x0A.
- start with op=ADD -> dout=0x08, carry=1. During the scan, sel and start toggling have no effect.
- Corner cases:
  - wr_en to src[2] with data 0x00 on the same edge as sel=0100, MOVE -> dout=0xF0 (old value); src[2]=0x00 afterwards.
  - rst_n=0 during cycle 2 of a scan -> all outputs 0, no done pulse, IDLE.
